// File: rtl/bcrypt_sched.sv
// bcrypt_sched: hands host jobs to a pool of bcrypt_loop cores and returns
// their results one at a time, with a per-core watchdog.
module bcrypt_sched #(
  parameter int NCORES = 4,
  parameter int CIDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  output logic [CIDX_W-1:0] job_core,
  output logic [NCORES-1:0] core_start,
  input  logic [NCORES-1:0] core_done,
  input  logic [31:0]       timeout_cycles,
  output logic              res_valid,
  output logic [CIDX_W-1:0] res_core,
  output logic              res_err,
  input  logic              res_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } coreState_t;

  coreState_t        r_state [NCORES];
  logic [31:0]       r_cnt   [NCORES];
  logic [NCORES-1:0] r_err;
  logic [NCORES-1:0] r_start;
  logic [CIDX_W-1:0] r_dptr;
  logic [CIDX_W-1:0] r_rptr;
  logic              r_lock;
  logic [CIDX_W-1:0] r_lockCore;

  logic              w_anyIdle;
  logic [CIDX_W-1:0] w_idleCore;
  logic              w_anyHold;
  logic [CIDX_W-1:0] w_holdCore;
  logic              w_accept;
  logic              w_release;
  coreState_t        w_nextState [NCORES];
  logic [31:0]       w_nextCnt   [NCORES];
  logic [NCORES-1:0] w_nextErr;

  // Adds an offset to a core index, wrapping modulo NCORES (works for non-power-of-two pools).
  function automatic logic [CIDX_W-1:0] wrapIdx(input logic [CIDX_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NCORES) sum = sum - NCORES;
    return CIDX_W'(sum);
  endfunction

  // Round-robin searches: first IDLE core from the dispatch pointer and first HOLD core from the result pointer.
  always_comb begin
    w_anyIdle  = 1'b0;
    w_idleCore = '0;
    w_anyHold  = 1'b0;
    w_holdCore = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (!w_anyIdle && r_state[wrapIdx(r_dptr, k)] == IDLE) begin
        w_anyIdle  = 1'b1;
        w_idleCore = wrapIdx(r_dptr, k);
      end
      if (!w_anyHold && r_state[wrapIdx(r_rptr, k)] == HOLD) begin
        w_anyHold  = 1'b1;
        w_holdCore = wrapIdx(r_rptr, k);
      end
    end
  end

  assign job_ready  = w_anyIdle;
  assign job_core   = w_idleCore;
  assign res_valid  = w_anyHold;
  assign res_core   = r_lock ? r_lockCore : w_holdCore;
  assign res_err    = r_err[res_core];
  assign core_start = r_start;
  assign w_accept   = job_valid && w_anyIdle;
  assign w_release  = w_anyHold && res_ready;

  // Per-core next state: dispatch, done/watchdog completion, host release and return to idle.
  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      w_nextState[i] = r_state[i];
      w_nextCnt[i]   = r_cnt[i];
      w_nextErr[i]   = r_err[i];
      case (r_state[i])
        IDLE: begin
          if (w_accept && w_idleCore == CIDX_W'(i)) begin
            w_nextState[i] = RUN;
            w_nextCnt[i]   = '0;
          end
        end
        RUN: begin
          if (core_done[i]) begin
            w_nextState[i] = HOLD;
            w_nextErr[i]   = 1'b0;
          end else if (timeout_cycles != 32'd0 &&
                       ({1'b0, r_cnt[i]} + 33'd1) >= {1'b0, timeout_cycles}) begin
            w_nextState[i] = HOLD;
            w_nextErr[i]   = 1'b1;
          end
          if (r_cnt[i] != '1) w_nextCnt[i] = r_cnt[i] + 32'd1;
        end
        HOLD: begin
          if (w_release && res_core == CIDX_W'(i)) w_nextState[i] = RELEASE;
        end
        RELEASE: begin
          w_nextState[i] = IDLE;
        end
        default: begin
          w_nextState[i] = IDLE;
        end
      endcase
    end
  end

  // State registers; core_start is registered from the next state so it follows RUN/HOLD exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCORES; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= '0;
      end
      r_err      <= '0;
      r_start    <= '0;
      r_dptr     <= '0;
      r_rptr     <= '0;
      r_lock     <= 1'b0;
      r_lockCore <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        r_state[i] <= w_nextState[i];
        r_cnt[i]   <= w_nextCnt[i];
        r_start[i] <= (w_nextState[i] == RUN) || (w_nextState[i] == HOLD);
      end
      r_err <= w_nextErr;
      if (w_accept) r_dptr <= wrapIdx(w_idleCore, 1);
      if (w_release) begin
        r_rptr <= wrapIdx(res_core, 1);
        r_lock <= 1'b0;
      end else if (w_anyHold) begin
        r_lock     <= 1'b1;
        r_lockCore <= res_core;
      end else begin
        r_lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcrypt_sched.sv
// Testbench for bcrypt_sched: directed scenarios plus randomized traffic
// checked by a scoreboard against a cycle-level behavioural model.
module tb_bcrypt_sched;

  localparam int NCORES = 4;
  localparam int CIDX_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              job_valid;
  logic              job_ready;
  logic [CIDX_W-1:0] job_core;
  logic [NCORES-1:0] core_start;
  logic [NCORES-1:0] core_done;
  logic [31:0]       timeout_cycles;
  logic              res_valid;
  logic [CIDX_W-1:0] res_core;
  logic              res_err;
  logic              res_ready;

  bcrypt_sched #(.NCORES(NCORES), .CIDX_W(CIDX_W)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_core(job_core),
    .core_start(core_start), .core_done(core_done),
    .timeout_cycles(timeout_cycles),
    .res_valid(res_valid), .res_core(res_core), .res_err(res_err),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int   core;
    logic err;
  } expRes_t;
  expRes_t expQ[$];

  // Behavioural model: 0 = free, 1 = owns a job (running or holding), 2 = releasing.
  int mState   [NCORES];
  int mAccEdge [NCORES];
  int mFinEdge [NCORES];
  int mDoneOff [NCORES];
  int mRelEdge [NCORES];
  int mDptr;
  int pendRel    = -1;
  int accPend    = -1;
  bit scoreOn    = 1'b0;
  bit prevLocked = 1'b0;
  logic [CIDX_W-1:0] prevCore;
  logic [NCORES-1:0] monStart;
  bit monValid;
  int monFound;

  // Compares one observed value with its expected value and tallies the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic applyStimulus(input logic jv, input logic [NCORES-1:0] done, input logic rr);
    job_valid = jv;
    core_done = done;
    res_ready = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_core_start"}, 32'(core_start), 32'd0);
    checkOutput({tag, "_job_ready"},  32'(job_ready),  32'd1);
    checkOutput({tag, "_job_core"},   32'(job_core),   32'd0);
    checkOutput({tag, "_res_valid"},  32'(res_valid),  32'd0);
    checkOutput({tag, "_res_core"},   32'(res_core),   32'd0);
    checkOutput({tag, "_res_err"},    32'(res_err),    32'd0);
  endtask

  // One random cycle: drive inputs from the model, then advance the model past the edge.
  task automatic driverStep(input bit allowJobs, input int T);
    logic [NCORES-1:0] done;
    bit   predReady;
    int   predCore;
    int   idx;
    int   d;
    logic e;
    logic jv;
    logic rr;
    done = '0;
    for (int c = 0; c < NCORES; c++) begin
      if (mState[c] == 1 && cyc < mFinEdge[c]) begin
        if (cyc == mAccEdge[c] + mDoneOff[c] - 1) done[c] = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        done[c] = 1'b1;
      end
    end
    predReady = 1'b0;
    predCore  = 0;
    for (int k = 0; k < NCORES; k++) begin
      idx = (mDptr + k) % NCORES;
      if (!predReady && mState[idx] == 0) begin
        predReady = 1'b1;
        predCore  = idx;
      end
    end
    checkOutput("job_ready", 32'(job_ready), 32'(predReady));
    if (predReady) checkOutput("job_core", 32'(job_core), 32'(predCore));
    jv = allowJobs && ($urandom_range(0, 1) == 1);
    rr = allowJobs ? ($urandom_range(0, 1) == 1) : 1'b1;
    applyStimulus(jv, done, rr);
    accPend = -1;
    if (jv && predReady) begin
      d = $urandom_range(1, 25);
      e = (T != 0 && T < d);
      expQ.push_back('{predCore, e});
      accPend            = predCore;
      mAccEdge[predCore] = cyc + 1;
      mDoneOff[predCore] = d;
      mFinEdge[predCore] = cyc + 1 + (e ? T : d);
      mDptr              = (predCore + 1) % NCORES;
    end
    tick();
    for (int c = 0; c < NCORES; c++)
      if (mState[c] == 2 && mRelEdge[c] < cyc) mState[c] = 0;
    if (pendRel >= 0) begin
      mState[pendRel]   = 2;
      mRelEdge[pendRel] = cyc;
      pendRel           = -1;
    end
    if (accPend >= 0) mState[accPend] = 1;
  endtask

  task automatic runSegment(input int T, input int ncyc);
    doReset();
    for (int c = 0; c < NCORES; c++) mState[c] = 0;
    mDptr          = 0;
    pendRel        = -1;
    prevLocked     = 1'b0;
    timeout_cycles = 32'(T);
    scoreOn        = 1'b1;
    for (int n = 0; n < ncyc + 100; n++) driverStep(n < ncyc, T);
    scoreOn = 1'b0;
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  // Monitor: on the falling edge compare DUT outputs with the model and retire handshaken results.
  initial begin
    forever begin
      @(negedge clk);
      if (scoreOn) begin
        monStart = '0;
        monValid = 1'b0;
        for (int c = 0; c < NCORES; c++) begin
          if (mState[c] == 1) begin
            monStart[c] = 1'b1;
            if (cyc >= mFinEdge[c]) monValid = 1'b1;
          end
        end
        checkOutput("core_start", 32'(core_start), 32'(monStart));
        checkOutput("res_valid", 32'(res_valid), 32'(monValid));
        if (prevLocked) checkOutput("res_core_locked", 32'(res_core), 32'(prevCore));
        if (res_valid && res_ready) begin
          monFound = -1;
          for (int q = 0; q < expQ.size(); q++)
            if (monFound < 0 && expQ[q].core == int'(res_core)) monFound = q;
          checkOutput("res_core_pending", 32'(monFound >= 0), 32'd1);
          if (monFound >= 0) begin
            checkOutput("res_err", 32'(res_err), 32'(expQ[monFound].err));
            expQ.delete(monFound);
          end
          pendRel = int'(res_core);
        end
        prevLocked = res_valid && !res_ready;
        prevCore   = res_core;
      end
    end
  end

  // Directed scenarios followed by randomized segments with different watchdog limits.
  initial begin
    rst            = 1'b1;
    timeout_cycles = 32'd0;
    applyStimulus(1'b0, '0, 1'b0);
    doReset();
    checkResetValues("reset");

    // Fill all four cores back to back.
    applyStimulus(1'b1, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("fill_job_ready", 32'(job_ready), 32'd1);
      checkOutput("fill_job_core", 32'(job_core), 32'(k));
      tick();
      checkOutput("fill_core_start", 32'(core_start), 32'((1 << (k + 1)) - 1));
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("full_job_ready", 32'(job_ready), 32'd0);

    // Core 2 finishes, is read and released, then becomes dispatchable again.
    applyStimulus(1'b0, 4'b0100, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("done2_res_valid", 32'(res_valid), 32'd1);
    checkOutput("done2_res_core", 32'(res_core), 32'd2);
    checkOutput("done2_res_err", 32'(res_err), 32'd0);
    checkOutput("done2_hold_start", 32'(core_start), 32'hf);
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rel2_core_start", 32'(core_start), 32'hb);
    checkOutput("rel2_job_ready", 32'(job_ready), 32'd0);
    tick();
    checkOutput("idle2_core_start", 32'(core_start), 32'hb);
    checkOutput("idle2_job_ready", 32'(job_ready), 32'd1);
    checkOutput("idle2_job_core", 32'(job_core), 32'd2);

    // Result lock: cores 1 and 3 hold, core 0 joins later without disturbing the presented core.
    doReset();
    applyStimulus(1'b1, '0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    applyStimulus(1'b0, 4'b1010, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("lock_first_core", 32'(res_core), 32'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("lock_held_core", 32'(res_core), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("lock_next_core", 32'(res_core), 32'd3);

    // Watchdog fires ten cycles after the core starts running.
    doReset();
    timeout_cycles = 32'd10;
    applyStimulus(1'b1, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int k = 1; k < 10; k++) begin
      tick();
      checkOutput("wd_not_yet", 32'(res_valid), 32'd0);
    end
    tick();
    checkOutput("wd_res_valid", 32'(res_valid), 32'd1);
    checkOutput("wd_res_core", 32'(res_core), 32'd0);
    checkOutput("wd_res_err", 32'(res_err), 32'd1);

    // Watchdog disabled: a core never completes on its own.
    doReset();
    timeout_cycles = 32'd0;
    applyStimulus(1'b1, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int k = 0; k < 1000; k++) tick();
    checkOutput("nowd_res_valid", 32'(res_valid), 32'd0);
    checkOutput("nowd_core_start", 32'(core_start), 32'h1);

    // Done and timeout on the same edge: done wins.
    doReset();
    timeout_cycles = 32'd5;
    applyStimulus(1'b1, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int k = 1; k < 5; k++) tick();
    applyStimulus(1'b0, 4'b0001, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("tie_res_valid", 32'(res_valid), 32'd1);
    checkOutput("tie_res_err", 32'(res_err), 32'd0);

    // Reset while a core holds, with a job offered at the same time.
    rst = 1'b1;
    applyStimulus(1'b1, '0, 1'b0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    checkResetValues("rst_hold");

    // Reset while a core runs.
    applyStimulus(1'b1, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetValues("rst_run");

    runSegment(0, 300);
    runSegment(7, 300);
    runSegment(15, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcrypt_sched.md
BCRYPT_SCHED -- requirements
Module: bcrypt_sched

Interface
REQ-001 SHALL have parameter NCORES, default 4: number of bcrypt_loop cores scheduled; legal range 2..16.
REQ-002 SHALL have parameter CIDX_W, default 2: core index width, equal to clog2(NCORES).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 job_valid  input  1  host offers a job; the core memory is already loaded with key and salt.
REQ-006 job_ready  output  1  scheduler can accept a job this cycle.
REQ-007 job_core  output  CIDX_W  core assigned to the job; valid while job_ready=1.
REQ-008 core_start  output  NCORES  per-core level start, one bit to each bcrypt_loop start input.
REQ-009 core_done  input  NCORES  per-core done from each bcrypt_loop.
REQ-010 timeout_cycles  input  32  watchdog limit in cycles; 0 disables the watchdog.
REQ-011 res_valid  output  1  a finished core's result memory is ready to read.
REQ-012 res_core  output  CIDX_W  index of the finished core.
REQ-013 res_err  output  1  qualifies res_valid: 1 = the job ended by timeout, not by done.
REQ-014 res_ready  input  1  host has finished reading the result and releases the core.

Function
REQ-015 Each core SHALL have a 2-bit state: IDLE, RUN, HOLD, RELEASE.
REQ-016 core_start[i] SHALL be a registered output equal to 1 exactly when core i is in RUN or HOLD.
REQ-017 job_ready SHALL be 1 iff at least one core is IDLE.
REQ-018 job_core SHALL be the first IDLE core found searching upward from dispatch pointer dptr, with wrap modulo NCORES.
REQ-019 Accept SHALL occur on a cycle with job_valid=1 and job_ready=1.
REQ-020 On accept, core job_core SHALL go IDLE->RUN at that edge, so core_start is 1 from the next cycle.
REQ-021 On accept, the core's watchdog counter SHALL clear to 0.
REQ-022 On accept, dptr SHALL become (job_core+1) mod NCORES.
REQ-023 In RUN, the watchdog counter SHALL increment by 1 per cycle and saturate at 2^32-1.
REQ-024 In RUN, core_done[i]=1 SHALL move the core to HOLD with err[i]=0.
REQ-025 In RUN, with timeout_cycles!=0 and counter+1 >= timeout_cycles, the core SHALL move to HOLD with err[i]=1.
REQ-026 If done and timeout occur in the same cycle, done SHALL win (err=0).
REQ-027 core_done SHALL be ignored in every state except RUN.
REQ-028 In HOLD, core_start SHALL stay 1, so the core keeps its result in memory for the host to read.
REQ-029 res_valid SHALL be 1 iff any core is in HOLD.
REQ-030 When res_valid is 1 and not locked, res_core SHALL be the first HOLD core searching upward from result pointer rptr.
REQ-031 res_err SHALL equal err[res_core].
REQ-032 While res_valid=1 and res_ready=0, res_core SHALL be locked and SHALL NOT change, even if other cores enter HOLD.
REQ-033 When res_valid=1 and res_ready=1 at an edge, core res_core SHALL go HOLD->RELEASE, the lock SHALL clear and rptr SHALL become res_core+1 mod NCORES.
REQ-034 RELEASE SHALL last exactly 1 cycle with core_start=0, which returns the core to its INIT state; the core then goes to IDLE.
REQ-035 A core in RELEASE SHALL NOT be eligible for dispatch.
REQ-036 An accept and a result handshake in the same cycle SHALL both take effect, on different cores.
REQ-037 Minimum latency SHALL be: accept at edge N -> core_start=1 after N; done sampled at edge M -> res_valid=1 after M.
REQ-038 job_ready, job_core, res_valid, res_core and res_err SHALL be combinational from registered state only, with no combinational path from job_valid or res_ready.

Reset
REQ-039 When rst=1 at an edge, every core SHALL go to IDLE and all core_start, err, counters, dptr, rptr and the lock SHALL clear to 0.
REQ-040 Reset value of every output: core_start=0, job_ready=1, job_core=0, res_valid=0, res_core=0, res_err=0.
REQ-041 rst SHALL override every other input, including mid-job; the resulting core_start=0 resets the cores.

Verification
REQ-042 After reset, hold job_valid=1 for 4 cycles -> job_core = 0,1,2,3 on consecutive accepts; core_start = 0001, 0011, 0111, 1111; then job_ready=0.
REQ-043 All 4 cores RUN; core_done=0100 for 1 cycle -> res_valid=1, res_core=2, res_err=0. res_ready=1 -> core_start[2]=0 for 1 cycle, then job_ready=1 with job_core=2.
REQ-044 Cores 1 and 3 both HOLD with rptr=0 and res_ready=0 -> res_core=1; core 0 enters HOLD meanwhile -> res_core stays 1. After the handshake -> res_core=3.
REQ-045 timeout_cycles=10, job accepted on core 0, no done -> HOLD 10 cycles after RUN entry with res_err=1. With timeout_cycles=0 and no done for 1000 cycles -> core stays in RUN.
REQ-046 Done and timeout on the same cycle -> res_err=0. Assert rst during RUN and HOLD -> all outputs at reset values next cycle.
